// File: rtl/cv32e40x_rvfi_retire_checker.sv
// cv32e40x_rvfi_retire_checker
// Passive checker on the core's RVFI retirement stream. It checks retirement order,
// PC continuity, interrupt-entry records and retirement after halt. It also counts
// valid retirements. Checks are combinational on rvfi_valid; results register on
// the next rising edge.
//
// Optional feature: define CV32E40X_RVFI_CHECK_MEM_EN to enable the memory-mask
// check. Without it, err_mem_o stays 0 and the mask ports are ignored.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clear_i             synchronous clear of all flags and counters (wins over rvfi_valid)
//   rvfi_*              RVFI retirement record
//   retire_cnt_o        valid retirements since reset/clear (wraps at 2^64)
//   err_*_o             sticky error flags
//   err_valid_o         one-cycle pulse after any failing retirement
//   err_order_val_o     rvfi_order of the first failing retirement
module cv32e40x_rvfi_retire_checker #(
   parameter logic [63:0] FIRST_ORDER = 64'd1,
   parameter int unsigned CHECK_PC    = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear_i,
   input  logic        rvfi_valid,
   input  logic [63:0] rvfi_order,
   input  logic [31:0] rvfi_pc_rdata,
   input  logic [31:0] rvfi_pc_wdata,
   input  logic [11:0] rvfi_trap,
   input  logic        rvfi_halt,
   input  logic [2:0]  rvfi_dbg,
   input  logic [96:0] rvfi_intr,
   input  logic [3:0]  rvfi_mem_rmask,
   input  logic [3:0]  rvfi_mem_wmask,
   output logic [63:0] retire_cnt_o,
   output logic        err_order_o,
   output logic        err_pc_o,
   output logic        err_intr_o,
   output logic        err_halt_o,
   output logic        err_mem_o,
   output logic        err_valid_o,
   output logic [63:0] err_order_val_o
);

   typedef enum logic [1:0] {StInit, StRun, StHalt} state_e;

   state_e state_q, state_d;
   logic   in_run, in_halt;

   logic [63:0] exp_order_q, exp_order_d;
   logic [31:0] prev_pc_wdata_q, prev_pc_wdata_d;
   logic        prev_trap_q, prev_trap_d;
   logic [63:0] retire_cnt_q, retire_cnt_d;
   logic        err_order_q, err_order_d;
   logic        err_pc_q, err_pc_d;
   logic        err_intr_q, err_intr_d;
   logic        err_halt_q, err_halt_d;
   logic        err_mem_q, err_mem_d;
   logic        err_valid_q, err_valid_d;
   logic [63:0] err_order_val_q, err_order_val_d;

   // Interrupt-entry record fields: {valid, order[63:0], pc_wdata[31:0]}
   logic        intr_valid;
   logic [63:0] intr_order;
   logic [31:0] intr_pc_wdata;

   logic order_fail, pc_fail, intr_fail, halt_fail, mem_fail, any_fail, any_sticky;
   logic unused_inputs;

   assign intr_valid    = rvfi_intr[96];
   assign intr_order    = rvfi_intr[95:32];
   assign intr_pc_wdata = rvfi_intr[31:0];

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StInit;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (clear_i) begin
         state_d = StInit;
      end else if (rvfi_valid) begin
         unique case (state_q)
            StInit:  state_d = rvfi_halt ? StHalt : StRun;
            StRun:   state_d = rvfi_halt ? StHalt : StRun;
            StHalt:  state_d = StHalt;
            default: state_d = StInit;
         endcase
      end
   end

   always_comb begin
      in_run  = (state_q == StRun);
      in_halt = (state_q == StHalt);
   end

   // ---------------- Checks ----------------
   assign order_fail = (rvfi_order != exp_order_q);

   // A discontinuity is legal on interrupt entry, debug entry or after a trap.
   assign pc_fail = (CHECK_PC != 0) && in_run && (rvfi_pc_rdata != prev_pc_wdata_q) &&
                    !intr_valid && (rvfi_dbg == 3'd0) && !prev_trap_q;

   assign intr_fail = intr_valid && ((intr_pc_wdata != rvfi_pc_rdata) ||
                                     (intr_order != (rvfi_order - 64'd1)));

   assign halt_fail = in_halt;

`ifdef CV32E40X_RVFI_CHECK_MEM_EN
   assign mem_fail = ((rvfi_mem_rmask != 4'd0) && (rvfi_mem_wmask != 4'd0)) ||
                     (rvfi_trap[0] && ((rvfi_mem_rmask | rvfi_mem_wmask) != 4'd0));
   assign unused_inputs = ^rvfi_trap[11:1];
`else
   assign mem_fail = 1'b0;
   assign unused_inputs = ^{rvfi_trap[11:1], rvfi_mem_rmask, rvfi_mem_wmask};
`endif

   assign any_fail   = order_fail | pc_fail | intr_fail | halt_fail | mem_fail;
   assign any_sticky = err_order_q | err_pc_q | err_intr_q | err_halt_q | err_mem_q;

   // ---------------- Datapath ----------------
   always_comb begin
      exp_order_d     = exp_order_q;
      prev_pc_wdata_d = prev_pc_wdata_q;
      prev_trap_d     = prev_trap_q;
      retire_cnt_d    = retire_cnt_q;
      err_order_d     = err_order_q;
      err_pc_d        = err_pc_q;
      err_intr_d      = err_intr_q;
      err_halt_d      = err_halt_q;
      err_mem_d       = err_mem_q;
      err_valid_d     = 1'b0;
      err_order_val_d = err_order_val_q;
      if (clear_i) begin
         exp_order_d     = FIRST_ORDER;
         prev_pc_wdata_d = 32'd0;
         prev_trap_d     = 1'b0;
         retire_cnt_d    = 64'd0;
         err_order_d     = 1'b0;
         err_pc_d        = 1'b0;
         err_intr_d      = 1'b0;
         err_halt_d      = 1'b0;
         err_mem_d       = 1'b0;
         err_order_val_d = 64'd0;
      end else if (rvfi_valid) begin
         // Resynchronise to the observed order so a gap is reported only once.
         exp_order_d     = rvfi_order + 64'd1;
         prev_pc_wdata_d = rvfi_pc_wdata;
         prev_trap_d     = rvfi_trap[0];
         retire_cnt_d    = retire_cnt_q + 64'd1;
         err_order_d     = err_order_q | order_fail;
         err_pc_d        = err_pc_q | pc_fail;
         err_intr_d      = err_intr_q | intr_fail;
         err_halt_d      = err_halt_q | halt_fail;
         err_mem_d       = err_mem_q | mem_fail;
         err_valid_d     = any_fail;
         if (any_fail && !any_sticky) begin
            err_order_val_d = rvfi_order;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_order_q     <= FIRST_ORDER;
         prev_pc_wdata_q <= 32'd0;
         prev_trap_q     <= 1'b0;
         retire_cnt_q    <= 64'd0;
         err_order_q     <= 1'b0;
         err_pc_q        <= 1'b0;
         err_intr_q      <= 1'b0;
         err_halt_q      <= 1'b0;
         err_mem_q       <= 1'b0;
         err_valid_q     <= 1'b0;
         err_order_val_q <= 64'd0;
      end else begin
         exp_order_q     <= exp_order_d;
         prev_pc_wdata_q <= prev_pc_wdata_d;
         prev_trap_q     <= prev_trap_d;
         retire_cnt_q    <= retire_cnt_d;
         err_order_q     <= err_order_d;
         err_pc_q        <= err_pc_d;
         err_intr_q      <= err_intr_d;
         err_halt_q      <= err_halt_d;
         err_mem_q       <= err_mem_d;
         err_valid_q     <= err_valid_d;
         err_order_val_q <= err_order_val_d;
      end
   end

   assign retire_cnt_o    = retire_cnt_q;
   assign err_order_o     = err_order_q;
   assign err_pc_o        = err_pc_q;
   assign err_intr_o      = err_intr_q;
   assign err_halt_o      = err_halt_q;
   assign err_mem_o       = err_mem_q;
   assign err_valid_o     = err_valid_q;
   assign err_order_val_o = err_order_val_q;

endmodule

// File: tb/tb_cv32e40x_rvfi_retire_checker.sv
// Testbench for cv32e40x_rvfi_retire_checker: directed scenarios with literal
// expectations, then randomized retirements compared every cycle to a reference model.
module tb_cv32e40x_rvfi_retire_checker;

   localparam logic [63:0] FIRST_ORDER = 64'd1;
   localparam int unsigned CHECK_PC    = 1;

`ifdef CV32E40X_RVFI_CHECK_MEM_EN
   localparam bit MEM_EN = 1'b1;
`else
   localparam bit MEM_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clear_i;
   logic        rvfi_valid;
   logic [63:0] rvfi_order;
   logic [31:0] rvfi_pc_rdata;
   logic [31:0] rvfi_pc_wdata;
   logic [11:0] rvfi_trap;
   logic        rvfi_halt;
   logic [2:0]  rvfi_dbg;
   logic [96:0] rvfi_intr;
   logic [3:0]  rvfi_mem_rmask;
   logic [3:0]  rvfi_mem_wmask;
   logic [63:0] retire_cnt_o;
   logic        err_order_o, err_pc_o, err_intr_o, err_halt_o, err_mem_o, err_valid_o;
   logic [63:0] err_order_val_o;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   cv32e40x_rvfi_retire_checker #(
      .FIRST_ORDER(FIRST_ORDER),
      .CHECK_PC   (CHECK_PC)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .clear_i        (clear_i),
      .rvfi_valid     (rvfi_valid),
      .rvfi_order     (rvfi_order),
      .rvfi_pc_rdata  (rvfi_pc_rdata),
      .rvfi_pc_wdata  (rvfi_pc_wdata),
      .rvfi_trap      (rvfi_trap),
      .rvfi_halt      (rvfi_halt),
      .rvfi_dbg       (rvfi_dbg),
      .rvfi_intr      (rvfi_intr),
      .rvfi_mem_rmask (rvfi_mem_rmask),
      .rvfi_mem_wmask (rvfi_mem_wmask),
      .retire_cnt_o   (retire_cnt_o),
      .err_order_o    (err_order_o),
      .err_pc_o       (err_pc_o),
      .err_intr_o     (err_intr_o),
      .err_halt_o     (err_halt_o),
      .err_mem_o      (err_mem_o),
      .err_valid_o    (err_valid_o),
      .err_order_val_o(err_order_val_o)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- Reference model ----------------
   // Stream position: started = a retirement seen since reset/clear, halted = a halt retired.
   logic [63:0] m_exp_order, m_cnt, m_err_val;
   logic [31:0] m_prev_pc;
   logic        m_prev_trap, m_started, m_halted;
   logic        m_eo, m_ep, m_ei, m_eh, m_em, m_ev;

   always @(posedge clk or negedge rst_n) begin : model
      bit f_o, f_p, f_i, f_h, f_m, f_any;
      if (!rst_n || clear_i) begin
         m_exp_order <= FIRST_ORDER;
         m_cnt <= 64'd0; m_err_val <= 64'd0; m_prev_pc <= 32'd0; m_prev_trap <= 1'b0;
         m_started <= 1'b0; m_halted <= 1'b0;
         m_eo <= 1'b0; m_ep <= 1'b0; m_ei <= 1'b0; m_eh <= 1'b0; m_em <= 1'b0; m_ev <= 1'b0;
      end else if (rvfi_valid) begin
         f_o = (rvfi_order != m_exp_order);
         f_p = (CHECK_PC != 0) && m_started && !m_halted && (rvfi_pc_rdata != m_prev_pc) &&
               !rvfi_intr[96] && (rvfi_dbg == 3'd0) && !m_prev_trap;
         f_i = rvfi_intr[96] && ((rvfi_intr[31:0] != rvfi_pc_rdata) ||
                                 (rvfi_intr[95:32] != rvfi_order - 64'd1));
         f_h = m_halted;
         f_m = MEM_EN && (((rvfi_mem_rmask != 0) && (rvfi_mem_wmask != 0)) ||
                          (rvfi_trap[0] && ((rvfi_mem_rmask | rvfi_mem_wmask) != 0)));
         f_any = f_o | f_p | f_i | f_h | f_m;
         if (f_any && !(m_eo | m_ep | m_ei | m_eh | m_em)) m_err_val <= rvfi_order;
         m_eo <= m_eo | f_o; m_ep <= m_ep | f_p; m_ei <= m_ei | f_i;
         m_eh <= m_eh | f_h; m_em <= m_em | f_m; m_ev <= f_any;
         m_exp_order <= rvfi_order + 64'd1;
         m_prev_pc   <= rvfi_pc_wdata;
         m_prev_trap <= rvfi_trap[0];
         m_cnt       <= m_cnt + 64'd1;
         m_started   <= 1'b1;
         m_halted    <= m_halted | rvfi_halt;
      end else begin
         m_ev <= 1'b0;
      end
   end

   // ---------------- Per-cycle compare ----------------
   always @(posedge clk) begin
      #3;
      chk("cmp_retire_cnt", retire_cnt_o, m_cnt);
      chk("cmp_err_order", {63'd0, err_order_o}, {63'd0, m_eo});
      chk("cmp_err_pc", {63'd0, err_pc_o}, {63'd0, m_ep});
      chk("cmp_err_intr", {63'd0, err_intr_o}, {63'd0, m_ei});
      chk("cmp_err_halt", {63'd0, err_halt_o}, {63'd0, m_eh});
      chk("cmp_err_mem", {63'd0, err_mem_o}, {63'd0, m_em});
      chk("cmp_err_valid", {63'd0, err_valid_o}, {63'd0, m_ev});
      chk("cmp_err_order_val", err_order_val_o, m_err_val);
   end

   // ---------------- Stimulus helpers ----------------
   task automatic idle_inputs();
      rvfi_valid = 1'b0; rvfi_order = '0; rvfi_pc_rdata = '0; rvfi_pc_wdata = '0;
      rvfi_trap = '0; rvfi_halt = 1'b0; rvfi_dbg = '0; rvfi_intr = '0;
      rvfi_mem_rmask = '0; rvfi_mem_wmask = '0;
   endtask

   // Called at a negedge; returns at the next negedge, after the capturing edge.
   task automatic retire(input logic [63:0] ord, input logic [31:0] pcr, input logic [31:0] pcw);
      rvfi_valid = 1'b1; rvfi_order = ord; rvfi_pc_rdata = pcr; rvfi_pc_wdata = pcw;
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic do_clear();
      clear_i = 1'b1;
      @(negedge clk);
      clear_i = 1'b0;
   endtask

   logic [63:0] ord;
   logic [31:0] pcr;

   initial begin
      rst_n = 1'b0; clear_i = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      chk("reset_cnt", retire_cnt_o, 64'd0);
      chk("reset_flags", {58'd0, err_order_o, err_pc_o, err_intr_o, err_halt_o, err_mem_o,
                          err_valid_o}, 64'd0);
      chk("reset_order_val", err_order_val_o, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // In-order, continuous retirements
      retire(64'd1, 32'h80, 32'h84);
      retire(64'd2, 32'h84, 32'h88);
      retire(64'd3, 32'h88, 32'h8c);
      chk("seq_cnt", retire_cnt_o, 64'd3);
      chk("seq_flags", {59'd0, err_order_o, err_pc_o, err_intr_o, err_halt_o, err_valid_o},
          64'd0);

      // Order gap 1 -> 3, then 4 resynchronised
      do_clear();
      retire(64'd1, 32'h80, 32'h84);
      retire(64'd3, 32'h84, 32'h88);
      chk("gap_err_order", {63'd0, err_order_o}, 64'd1);
      chk("gap_pulse", {63'd0, err_valid_o}, 64'd1);
      chk("gap_order_val", err_order_val_o, 64'd3);
      @(negedge clk);
      chk("gap_pulse_gone", {63'd0, err_valid_o}, 64'd0);
      retire(64'd4, 32'h88, 32'h8c);
      chk("gap_no_repulse", {63'd0, err_valid_o}, 64'd0);
      chk("gap_order_val_kept", err_order_val_o, 64'd3);

      // PC jump covered by a consistent interrupt record
      do_clear();
      retire(64'd1, 32'hfc, 32'h100);
      rvfi_intr = {1'b1, 64'd1, 32'h200};
      retire(64'd2, 32'h200, 32'h204);
      chk("intr_ok_pc", {63'd0, err_pc_o}, 64'd0);
      chk("intr_ok_intr", {63'd0, err_intr_o}, 64'd0);
      // Same jump without the record
      do_clear();
      retire(64'd1, 32'hfc, 32'h100);
      retire(64'd2, 32'h200, 32'h204);
      chk("jump_err_pc", {63'd0, err_pc_o}, 64'd1);
      chk("jump_order_val", err_order_val_o, 64'd2);

      // Retirement after halt, then clear
      do_clear();
      rvfi_halt = 1'b1;
      retire(64'd1, 32'h80, 32'h84);
      chk("halt_first_ok", {63'd0, err_halt_o}, 64'd0);
      retire(64'd2, 32'h84, 32'h88);
      chk("halt_err", {63'd0, err_halt_o}, 64'd1);
      do_clear();
      retire(64'd1, 32'h80, 32'h84);
      chk("halt_clear_flags", {60'd0, err_order_o, err_pc_o, err_intr_o, err_halt_o}, 64'd0);
      chk("halt_clear_cnt", retire_cnt_o, 64'd1);

      // Clear and retirement in the same cycle: retirement dropped
      clear_i = 1'b1;
      retire(64'd7, 32'h80, 32'h84);
      clear_i = 1'b0;
      chk("clr_drop_cnt", retire_cnt_o, 64'd0);
      // Back in INIT: arbitrary PC is not checked, order must be FIRST_ORDER
      retire(64'd1, 32'h1234, 32'h1238);
      chk("clr_init_order", {63'd0, err_order_o}, 64'd0);
      chk("clr_init_pc", {63'd0, err_pc_o}, 64'd0);

      // Memory mask conflict
      do_clear();
      rvfi_mem_rmask = 4'hf; rvfi_mem_wmask = 4'h1;
      retire(64'd1, 32'h80, 32'h84);
      chk("mem_flag", {63'd0, err_mem_o}, {63'd0, MEM_EN});

      // Randomized phase
      do_clear();
      for (int i = 0; i < 4000; i++) begin
         rst_n   = ($urandom_range(0, 299) != 0);
         clear_i = ($urandom_range(0, 99) < 2);
         rvfi_valid = ($urandom_range(0, 99) < 70);
         case ($urandom_range(0, 19))
            0:       ord = m_exp_order + 64'($urandom_range(2, 5));
            1:       ord = m_exp_order - 64'd1;
            2:       ord = 64'hffff_ffff_ffff_ffff;
            default: ord = m_exp_order;
         endcase
         pcr = ($urandom_range(0, 99) < 85) ? m_prev_pc : $urandom;
         rvfi_order    = ord;
         rvfi_pc_rdata = pcr;
         rvfi_pc_wdata = ($urandom_range(0, 99) < 80) ? pcr + 32'd4 : $urandom;
         rvfi_trap     = {11'($urandom), ($urandom_range(0, 99) < 10)};
         rvfi_halt     = ($urandom_range(0, 99) < 3);
         rvfi_dbg      = ($urandom_range(0, 99) < 5) ? 3'($urandom_range(1, 7)) : 3'd0;
         if ($urandom_range(0, 99) < 10)
            rvfi_intr = {1'b1,
                         ($urandom_range(0, 99) < 80) ? ord - 64'd1 : {$urandom, $urandom},
                         ($urandom_range(0, 99) < 80) ? pcr : 32'($urandom)};
         else
            rvfi_intr = {1'b0, {$urandom, $urandom}, 32'($urandom)};
         if ($urandom_range(0, 99) < 60) begin
            rvfi_mem_rmask = 4'd0; rvfi_mem_wmask = 4'd0;
         end else begin
            rvfi_mem_rmask = 4'($urandom); rvfi_mem_wmask = 4'($urandom);
         end
         @(negedge clk);
      end
      rst_n = 1'b1; clear_i = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
